// File: rtl/nic8_pkg.sv
// Shared encodings for the 8-bit register-transfer datapath: source codes,
// destination mask bit positions and the transfer sequencer state type.
package nic8_pkg;

    localparam logic [1:0] SRC_A   = 2'b00;
    localparam logic [1:0] SRC_X   = 2'b01;
    localparam logic [1:0] SRC_IMM = 2'b10;
    localparam logic [1:0] SRC_RSV = 2'b11;

    // Destination mask is {A,B,X,Q}, A in the MSB.
    localparam int DST_A = 3;
    localparam int DST_B = 2;
    localparam int DST_X = 1;
    localparam int DST_Q = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        TURN  = 2'd3
    } xfer_state_e;

endpackage

// File: rtl/reg_xfer_sequencer_rr_arbiter.sv
// Round-robin arbiter: the requester at index ptr has highest priority, then ptr+1, ptr+2, ...
// Latency: purely combinational, grant valid in the same cycle as req.
// Backpressure: en low forces an all-zero grant.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx
);

    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (en && !found && req[i] && (((int'(ptr) + k) % NREQ) == i)) begin
                    found    = 1'b1;
                    grant[i] = 1'b1;
                    idx      = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/reg_xfer_sequencer.sv
// Sequences A/X/immediate -> {A,B,X,Q} transfers on the shared dbus for NREQ round-robin requesters.
// Latency: accept t, drive t+1, load+done t+2, TURN_CYCLES released cycles, next accept t+3+TURN_CYCLES.
// Backpressure: req_ready is only offered in IDLE; requesters hold req_valid until they see ready.
module reg_xfer_sequencer
    import nic8_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int DATA_W      = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [2*NREQ-1:0]      req_src,
    input  logic [4*NREQ-1:0]      req_dst,
    input  logic [DATA_W*NREQ-1:0] req_imm,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        req_done,
    output logic [NREQ-1:0]        req_err,
    output logic                   load_a,
    output logic                   load_b,
    output logic                   load_x,
    output logic                   load_q,
    output logic                   assert_bar_a,
    output logic                   assert_bar_x,
    output logic [DATA_W-1:0]      dbus_out,
    output logic                   dbus_oe,
    output logic                   busy
);

    localparam int         IW        = (NREQ > 2) ? 2 : 1;
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    xfer_state_e       state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
    logic [1:0]        src_q, src_d;
    logic [3:0]        dst_q, dst_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [1:0]        turn_cnt_q, turn_cnt_d;

    logic [3:0]        ld_vec_q, ld_vec_d;
    logic              bar_a_q, bar_a_d;
    logic              bar_x_q, bar_x_d;
    logic              oe_q, oe_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [NREQ-1:0]   err_q, err_d;
    logic              busy_q, busy_d;

    logic              arb_en;
    logic [NREQ-1:0]   arb_grant;
    logic [IW-1:0]     arb_idx;
    logic [1:0]        sel_src;
    logic [3:0]        sel_dst;
    logic [DATA_W-1:0] sel_imm;
    logic              drv_en;
    logic [1:0]        drv_src;
    logic [DATA_W-1:0] drv_imm;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // No grant while reset is sampled, so a requester never sees a handshake that gets discarded.
    assign arb_en = (state_q == IDLE) && !reset;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .en    (arb_en),
        .grant (arb_grant),
        .idx   (arb_idx)
    );

    assign req_ready = arb_grant;

    always_comb begin
        sel_src = '0;
        sel_dst = '0;
        sel_imm = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_grant[i]) begin
                sel_src = req_src[2*i +: 2];
                sel_dst = req_dst[4*i +: 4];
                sel_imm = req_imm[DATA_W*i +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        src_d      = src_q;
        dst_d      = dst_q;
        imm_d      = imm_q;
        turn_cnt_d = turn_cnt_q;
        ld_vec_d   = '0;
        done_d     = '0;
        err_d      = '0;
        drv_en     = 1'b0;
        drv_src    = SRC_A;
        drv_imm    = '0;

        case (state_q)
            IDLE: begin
                if (|arb_grant) begin
                    gnt_idx_d = arb_idx;
                    src_d     = sel_src;
                    dst_d     = sel_dst;
                    imm_d     = sel_imm;
                    if (sel_src == SRC_RSV) begin
                        err_d      = arb_grant;
                        state_d    = TURN;
                        turn_cnt_d = TURN_LAST;
                        ptr_d      = next_idx(arb_idx);
                    end else begin
                        state_d = DRIVE;
                        drv_en  = 1'b1;
                        drv_src = sel_src;
                        drv_imm = sel_imm;
                    end
                end
            end
            DRIVE: begin
                state_d  = LOAD;
                drv_en   = 1'b1;
                drv_src  = src_q;
                drv_imm  = imm_q;
                ld_vec_d = dst_q;
                for (int i = 0; i < NREQ; i++) begin
                    if (gnt_idx_q == IW'(i)) begin
                        done_d[i] = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d    = TURN;
                turn_cnt_d = TURN_LAST;
                ptr_d      = next_idx(gnt_idx_q);
            end
            TURN: begin
                if (turn_cnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    turn_cnt_d = turn_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Driver enables are a function of the source code alone, so only one can ever be active.
    always_comb begin
        bar_a_d = 1'b1;
        bar_x_d = 1'b1;
        oe_d    = 1'b0;
        dout_d  = '0;
        if (drv_en) begin
            case (drv_src)
                SRC_A:   bar_a_d = 1'b0;
                SRC_X:   bar_x_d = 1'b0;
                SRC_IMM: begin
                    oe_d   = 1'b1;
                    dout_d = drv_imm;
                end
                default: ;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            gnt_idx_q  <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            imm_q      <= '0;
            turn_cnt_q <= '0;
            ld_vec_q   <= '0;
            bar_a_q    <= 1'b1;
            bar_x_q    <= 1'b1;
            oe_q       <= 1'b0;
            dout_q     <= '0;
            done_q     <= '0;
            err_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            imm_q      <= imm_d;
            turn_cnt_q <= turn_cnt_d;
            ld_vec_q   <= ld_vec_d;
            bar_a_q    <= bar_a_d;
            bar_x_q    <= bar_x_d;
            oe_q       <= oe_d;
            dout_q     <= dout_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    assign load_a       = ld_vec_q[DST_A];
    assign load_b       = ld_vec_q[DST_B];
    assign load_x       = ld_vec_q[DST_X];
    assign load_q       = ld_vec_q[DST_Q];
    assign assert_bar_a = bar_a_q;
    assign assert_bar_x = bar_x_q;
    assign dbus_oe      = oe_q;
    assign dbus_out     = dout_q;
    assign req_done     = done_q;
    assign req_err      = err_q;
    assign busy         = busy_q;

endmodule
